// File: rtl/pio_pkg.sv
// Shared constants for the key/switch input PIO: register map and edge-select encodings.
package pio_pkg;

  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CAPTURE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/input_debounce.sv
// One input bit: two-flop synchroniser followed by a hold-time debouncer.
module input_debounce
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic stable_o
);

  localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept the new level once it has differed from stable for DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM input PIO: debounced keys, edge capture register, irq mask and level interrupt.
module key_input_pio
  import pio_pkg::*;
#(
  parameter int unsigned     WIDTH           = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [WIDTH-1:0]  writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  readdata,
  output logic              irq
);

  logic [WIDTH-1:0] stable_c;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] edge_sel_c;
  logic [WIDTH-1:0] clr_c;
  logic             wr_c;
  logic             rd_c;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             irq_q;
  logic             irq_d;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[g])
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .din_i    (in_port[g]),
      .stable_o (stable_c[g])
    );
  end

  assign wr_c = chipselect & ~write_n;
  assign rd_c = chipselect & ~read_n;

  // Register updates; reads always see the state before any same-cycle write.
  always_comb begin
    edge_sel_c = '0;
    clr_c      = '0;
    mask_d     = mask_q;
    rdata_d    = rdata_q;

    if (EDGE_TYPE == EDGE_RISE) begin
      edge_sel_c = stable_c & ~stable_dly_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_sel_c = ~stable_c & stable_dly_q;
    end else begin
      edge_sel_c = stable_c ^ stable_dly_q;
    end

    if (wr_c && (address == ADDR_MASK)) begin
      mask_d = writedata;
    end
    if (wr_c && (address == ADDR_CAPTURE)) begin
      clr_c = writedata;
    end

    // Set wins over clear on the same bit.
    cap_d = (cap_q & ~clr_c) | edge_sel_c;
    irq_d = |(cap_q & mask_q);

    if (rd_c) begin
      case (address)
        ADDR_DATA:    rdata_d = stable_c;
        ADDR_MASK:    rdata_d = mask_q;
        ADDR_CAPTURE: rdata_d = cap_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_dly_q <= RESET_LEVEL;
      mask_q       <= '0;
      cap_q        <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_c;
      mask_q       <= mask_d;
      cap_q        <= cap_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_input_pio.sv
// Scoreboard bench for key_input_pio: windowed behavioural model, directed cases, random traffic.
module tb_key_input_pio;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam logic [3:0]  RL = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] address;
  logic       chipselect;
  logic       read_n;
  logic       write_n;
  logic [3:0] writedata;
  logic [3:0] in_port;
  logic [3:0] readdata;
  logic       irq;

  always #5 clk = ~clk;

  key_input_pio #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .EDGE_TYPE       (1),
    .RESET_LEVEL     (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samp[k] is in_port as sampled k edges ago. A bit's debounced level
  // flips when the D synchronised samples (2..D+1 edges old) all disagree with it.
  logic [3:0] samp [D+2];
  logic [3:0] m_stable   = RL;
  logic [3:0] m_stable_d = RL;
  logic [3:0] m_cap      = '0;
  logic [3:0] m_mask     = '0;
  logic [3:0] m_rd       = '0;
  logic       m_irq      = 1'b0;
  bit         rd_pend    = 1'b0;
  logic [3:0] exp_q [$];

  always @(posedge clk) begin
    logic [3:0] e, clr, nst, ncap, nmask;
    logic       nirq;
    bit         all_new;
    if (reset) begin
      for (int k = 0; k < int'(D) + 2; k++) samp[k] = RL;
      m_stable = RL; m_stable_d = RL; m_cap = '0; m_mask = '0;
      m_irq = 1'b0; m_rd = '0; rd_pend = 1'b0;
    end else begin
      rd_pend = 1'b0;
      if (chipselect && !read_n) begin
        case (address)
          2'd0:    e = m_stable;
          2'd2:    e = m_mask;
          2'd3:    e = m_cap;
          default: e = '0;
        endcase
        exp_q.push_back(e);
        m_rd = e;
        rd_pend = 1'b1;
      end
      clr   = (chipselect && !write_n && address == 2'd3) ? writedata : 4'h0;
      nmask = (chipselect && !write_n && address == 2'd2) ? writedata : m_mask;
      nirq  = |(m_cap & m_mask);
      ncap  = (m_cap & ~clr) | (~m_stable & m_stable_d);
      for (int k = int'(D) + 1; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = in_port;
      nst = m_stable;
      for (int b = 0; b < int'(W); b++) begin
        all_new = 1'b1;
        for (int k = 2; k < int'(D) + 2; k++)
          if (samp[k][b] == m_stable[b]) all_new = 1'b0;
        if (all_new) nst[b] = ~m_stable[b];
      end
      m_stable_d = m_stable;
      m_stable   = nst;
      m_cap      = ncap;
      m_mask     = nmask;
      m_irq      = nirq;
    end
  end

  // Monitor: a read issued at the last edge pops its expected value; otherwise readdata holds.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 4'h1, 4'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_readdata", readdata, e);
      end
    end else begin
      chk("hold_readdata", readdata, m_rd);
    end
    chk("sb_irq", {3'b0, irq}, {3'b0, m_irq});
  end

  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    address = '0; writedata = '0; in_port = 4'hF; reset = 1'b1;
    tick(3);
    chk("reset_readdata", readdata, 4'h0);
    chk("reset_irq", {3'b0, irq}, 4'h0);
    reset = 1'b0;
    tick(2);

    // 1: idle keys read back as F, nothing captured
    do_read(2'd0); chk("t1_data", readdata, 4'hF);
    do_read(2'd3); chk("t1_cap", readdata, 4'h0);
    chk("t1_irq", {3'b0, irq}, 4'h0);

    // 2: fall on bit 0 lands in capture at edge 7, first visible to the read at edge 8
    in_port = 4'hE;
    for (int k = 1; k <= 10; k++) begin
      do_read(2'd3);
      chk("t2_cap_latency", readdata, (k >= 8) ? 4'h1 : 4'h0);
      chk("t2_irq_masked", {3'b0, irq}, 4'h0);
    end
    in_port = 4'hF; tick(10);
    do_write(2'd3, 4'h1);

    // 3: masked capture raises irq one clock after capture; clearing drops both
    do_write(2'd2, 4'h1);
    in_port = 4'hE;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk("t3_irq_latency", {3'b0, irq}, (k >= 8) ? 4'h1 : 4'h0);
    end
    do_write(2'd3, 4'h1);
    do_read(2'd3);
    chk("t3_cap_cleared", readdata, 4'h0);
    chk("t3_irq_cleared", {3'b0, irq}, 4'h0);
    in_port = 4'hF; tick(10);

    // 4: three-cycle glitch on bit 1 is rejected
    in_port = 4'hD; tick(3); in_port = 4'hF; tick(10);
    do_read(2'd0); chk("t4_data", readdata, 4'hF);
    do_read(2'd3); chk("t4_cap", readdata, 4'h0);

    // 5: clear of bit 2 on the capture edge loses to the set
    in_port = 4'hB; tick(6);
    do_write(2'd3, 4'h4);
    do_read(2'd3); chk("t5_set_wins", readdata, 4'h4);
    in_port = 4'hF; tick(10);
    do_write(2'd3, 4'hF);

    // 6: reset mid-debounce drops the pending count
    in_port = 4'h7; tick(4);
    reset = 1'b1; in_port = 4'hF; tick(1);
    chk("t6_reset_rd", readdata, 4'h0);
    chk("t6_reset_irq", {3'b0, irq}, 4'h0);
    reset = 1'b0; tick(10);
    do_read(2'd0); chk("t6_data", readdata, 4'hF);
    do_read(2'd3); chk("t6_cap", readdata, 4'h0);

    // Random traffic against the model
    do_write(2'd2, 4'hF);
    for (int i = 0; i < 2000; i++) begin
      int op;
      if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
      op = int'($urandom_range(0, 9));
      reset = ($urandom_range(0, 299) == 0);
      chipselect = (op >= 3);
      address    = 2'($urandom);
      writedata  = 4'($urandom);
      read_n     = !(op == 3 || op == 4 || op == 7 || op == 9);
      write_n    = !(op == 5 || op == 6 || op == 8 || op == 9);
      tick(1);
    end
    idle(); reset = 1'b0;
    tick(3);
    chk("sb_drained", 4'(exp_q.size()), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
